// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end: default widths, queue entry
// layout and the saturating-counter helper used by the optional statistics.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;
  localparam int STATS_W     = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v,
                                                 input logic               en);
    if (en && (v != {STATS_W{1'b1}})) begin
      return v + {{(STATS_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch FIFO with a registered head view. Pointers wrap at DEPTH, so
// any DEPTH >= 2 works; the head register keeps the last entry while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  entry_t           i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output entry_t           o_head,
  output logic [LVL_W-1:0] o_level
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_valid;
  entry_t           r_head;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_next;
  logic [LVL_W-1:0] w_level_next;
  logic             w_valid_next;
  entry_t           w_head_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_pop     = i_pop && (r_level != ZERO_LVL);
  assign w_push    = i_push && ((r_level != FULL_LVL) || w_pop);
  assign w_rd_next = ptr_inc(r_rd_ptr);

  // Next occupancy and the entry decode will see at the head next cycle.
  always_comb begin
    w_level_next = r_level;
    w_valid_next = 1'b0;
    w_head_next  = r_head;
    if (i_flush) begin
      w_level_next = ZERO_LVL;
    end else begin
      w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_level_next == ZERO_LVL) begin
        w_valid_next = 1'b0;
      end else if (w_pop) begin
        w_valid_next = 1'b1;
        w_head_next  = (r_level > LVL_W'(1)) ? r_mem[w_rd_next] : i_push_data;
      end else if (r_level == ZERO_LVL) begin
        w_valid_next = 1'b1;
        w_head_next  = i_push_data;
      end else begin
        w_valid_next = 1'b1;
        w_head_next  = r_mem[r_rd_ptr];
      end
    end
  end

  // Pointers, level and head view; a flush rewinds both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_level  <= ZERO_LVL;
      r_valid  <= 1'b0;
      r_head   <= {$bits(entry_t){1'b0}};
    end else begin
      r_level <= w_level_next;
      r_valid <= w_valid_next;
      r_head  <= w_head_next;
      if (i_flush) begin
        r_rd_ptr <= {PTR_W{1'b0}};
        r_wr_ptr <= {PTR_W{1'b0}};
      end else begin
        if (w_pop) begin
          r_rd_ptr <= w_rd_next;
        end
        if (w_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {$bits(entry_t){1'b0}};
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_level = r_level;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, one outstanding imem read, prefetch queue and
// decode handshake. Defining FETCH_STATS_EN adds saturating transfer/redirect counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                         orig_clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FETCH_STATS_EN
  ,
  output logic [STATS_W-1:0]           fetched_cnt,
  output logic [STATS_W-1:0]           flush_cnt
`endif
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tag_pc;
  logic              r_inflight;
  logic              r_started;

  logic              w_room;
  logic              w_req;
  logic              w_xfer;
  logic              w_push;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_valid;
  logic [LVL_W-1:0]  w_level;

  // In-flight read reserves a slot so the response always has room to land.
  assign w_room       = ({1'b0, w_level} + {{LVL_W{1'b0}}, r_inflight}) < (LVL_W + 1)'(DEPTH);
  assign w_req        = r_started && !redirect_valid && w_room;
  assign w_xfer       = w_valid && out_ready;
  assign w_push       = r_inflight && !redirect_valid;
  assign w_push_entry = '{pc: r_tag_pc, instr: imem_data};

  // PC, request tag and the single outstanding-read flag; redirect kills the read.
  always_ff @(posedge orig_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_tag_pc   <= {ADDR_W{1'b0}};
      r_inflight <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (redirect_valid) begin
        r_pc       <= redirect_pc;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_req;
        if (w_req) begin
          r_tag_pc <= r_pc;
          r_pc     <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .LVL_W   (LVL_W)
  ) u_fifo (
    .clk         (orig_clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .i_flush     (redirect_valid),
    .o_valid     (w_valid),
    .o_head      (w_head),
    .o_level     (w_level)
  );

`ifdef FETCH_STATS_EN
  logic [STATS_W-1:0] r_fetched_cnt;
  logic [STATS_W-1:0] r_flush_cnt;

  // Saturating counts of delivered instructions and redirects.
  always_ff @(posedge orig_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetched_cnt <= {STATS_W{1'b0}};
      r_flush_cnt   <= {STATS_W{1'b0}};
    end else begin
      r_fetched_cnt <= sat_inc(r_fetched_cnt, w_xfer);
      r_flush_cnt   <= sat_inc(r_flush_cnt, redirect_valid);
    end
  end

  assign fetched_cnt = r_fetched_cnt;
  assign flush_cnt   = r_flush_cnt;
`endif

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign out_valid = w_valid;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign level     = w_level;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: two instances (DEPTH=4/RESET_PC=0 and
// DEPTH=3/RESET_PC=0xFE) checked each cycle against a queue-level reference model.
module tb_fetch_queue_unit;

  localparam int AW   = 8;
  localparam int IW   = 32;
  localparam int ND   = 2;
  localparam int DEP0 = 4;
  localparam int DEP1 = 3;

  logic          orig_clk       = 1'b0;
  logic          rst_n          = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc    = 8'h00;
  logic          out_ready      = 1'b0;
  logic [IW-1:0] imem_data [ND];
  logic          imem_req  [ND];
  logic [AW-1:0] imem_addr [ND];
  logic          out_valid [ND];
  logic [IW-1:0] out_instr [ND];
  logic [AW-1:0] out_pc    [ND];
  logic [2:0]    level0;
  logic [1:0]    level1;
`ifdef FETCH_STATS_EN
  logic [15:0]   fetched_cnt [ND];
  logic [15:0]   flush_cnt   [ND];
`endif

  always #5 orig_clk = ~orig_clk;

  fetch_queue_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEP0), .RESET_PC(8'h00)) dut0 (
    .orig_clk(orig_clk), .rst_n(rst_n), .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
    .imem_data(imem_data[0]), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_instr(out_instr[0]),
    .out_pc(out_pc[0]), .level(level0)
`ifdef FETCH_STATS_EN
    , .fetched_cnt(fetched_cnt[0]), .flush_cnt(flush_cnt[0])
`endif
  );

  fetch_queue_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEP1), .RESET_PC(8'hFE)) dut1 (
    .orig_clk(orig_clk), .rst_n(rst_n), .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
    .imem_data(imem_data[1]), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_instr(out_instr[1]),
    .out_pc(out_pc[1]), .level(level1)
`ifdef FETCH_STATS_EN
    , .fetched_cnt(fetched_cnt[1]), .flush_cnt(flush_cnt[1])
`endif
  );

  // Reference model: a plain list of queued {pc, instr} words per instance.
  logic [AW+IW-1:0] mbuf  [ND][8];
  int               mcnt  [ND];
  logic [AW-1:0]    mpc   [ND];
  logic [AW-1:0]    mtag  [ND];
  bit               minf  [ND];
  bit               mstart[ND];
  bit               msent [ND];
  logic [AW-1:0]    maddr [ND];
  logic [AW+IW-1:0] mlast [ND];
  int               mfetch[ND];
  int               mflush[ND];

  int n_cmp = 0;
  int n_err = 0;
  int p_ready = 100;
  int p_redir = 0;

  function automatic int dep_of(input int k);
    return (k == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [AW-1:0] rpc_of(input int k);
    return (k == 0) ? 8'h00 : 8'hFE;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_req(input int k);
    return mstart[k] && !redirect_valid && ((mcnt[k] + int'(minf[k])) < dep_of(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      mcnt[k] = 0; mpc[k] = rpc_of(k); mtag[k] = 8'h00; minf[k] = 1'b0;
      mstart[k] = 1'b0; msent[k] = 1'b0; maddr[k] = 8'h00;
      mlast[k] = 40'h0; mfetch[k] = 0; mflush[k] = 0;
    end
  endtask

  task automatic model_step();
    bit            req;
    bit            pop;
    logic [IW-1:0] d;
    for (int k = 0; k < ND; k++) begin
      req = exp_req(k);
      pop = (mcnt[k] > 0) && out_ready;
      d   = imem_data[k];
      if (pop && mfetch[k] < 65535) mfetch[k]++;
      if (redirect_valid) begin
        if (mflush[k] < 65535) mflush[k]++;
        mcnt[k] = 0; mpc[k] = redirect_pc; minf[k] = 1'b0; msent[k] = 1'b0;
      end else begin
        if (pop) begin
          for (int i = 0; i < 7; i++) mbuf[k][i] = mbuf[k][i+1];
          mcnt[k]--;
        end
        if (minf[k]) begin
          mbuf[k][mcnt[k]] = {mtag[k], d};
          mcnt[k]++;
        end
        msent[k] = req;
        maddr[k] = mpc[k];
        minf[k]  = req;
        if (req) begin
          mtag[k] = mpc[k];
          mpc[k]  = mpc[k] + 8'h01;
        end
      end
      mstart[k] = 1'b1;
    end
  endtask

  task automatic drive(input int frc);
    for (int k = 0; k < ND; k++)
      imem_data[k] = msent[k] ? ({24'h0, maddr[k]} + 32'h100) : $urandom();
    out_ready      = ($urandom_range(99) < p_ready);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = ($urandom_range(3) == 0) ? mpc[0] : 8'($urandom());
    if (frc >= 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = 8'(frc);
    end
  endtask

  task automatic check_all();
    logic [AW+IW-1:0] h;
    int               lv;
    for (int k = 0; k < ND; k++) begin
      h  = (mcnt[k] > 0) ? mbuf[k][0] : mlast[k];
      lv = (k == 0) ? int'(level0) : int'(level1);
      chk($sformatf("req%0d", k),   64'(imem_req[k]),  64'(exp_req(k)));
      chk($sformatf("addr%0d", k),  64'(imem_addr[k]), 64'(mpc[k]));
      chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(mcnt[k] > 0));
      chk($sformatf("level%0d", k), 64'(lv),           64'(mcnt[k]));
      chk($sformatf("pc%0d", k),    64'(out_pc[k]),    64'(h[AW+IW-1:IW]));
      chk($sformatf("instr%0d", k), 64'(out_instr[k]), 64'(h[IW-1:0]));
`ifdef FETCH_STATS_EN
      chk($sformatf("fetched%0d", k), 64'(fetched_cnt[k]), 64'(mfetch[k]));
      chk($sformatf("flushes%0d", k), 64'(flush_cnt[k]),   64'(mflush[k]));
`endif
      if (mcnt[k] > 0) mlast[k] = mbuf[k][0];
    end
  endtask

  task automatic cycle(input int frc);
    @(posedge orig_clk);
    if (rst_n) model_step();
    #1;
    drive(frc);
    @(negedge orig_clk);
    check_all();
  endtask

  task automatic async_reset_pulse();
    @(negedge orig_clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("arst_valid%0d", k), 64'(out_valid[k]), 64'h0);
      chk($sformatf("arst_req%0d", k),   64'(imem_req[k]),  64'h0);
    end
    chk("arst_level0", 64'(level0), 64'h0);
    chk("arst_level1", 64'(level1), 64'h0);
    model_reset();
    cycle(-1);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    model_reset();
    for (int k = 0; k < ND; k++) imem_data[k] = $urandom();
    #1 rst_n = 1'b0;
    #2 check_all();
    cycle(-1);
    #2 rst_n = 1'b1;

    // Streaming with decode always ready.
    p_ready = 100; p_redir = 0;
    repeat (12) cycle(-1);

    // Back-pressure until full, then drain.
    p_ready = 0;
    repeat (10) cycle(-1);
    p_ready = 100;
    repeat (8) cycle(-1);

    // Redirect to 0x40 with three queued entries and one read in flight.
    p_ready = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mcnt[0] == 3 && minf[0]) found = 1'b1;
      else cycle(-1);
    end
    chk("redir_setup", 64'(found), 64'h1);
    cycle(8'h40);
    p_ready = 100;
    repeat (6) cycle(-1);

    // Randomized phases with varying back-pressure and redirect rates.
    for (int ph = 0; ph < 6; ph++) begin
      p_ready = $urandom_range(100);
      p_redir = $urandom_range(15);
      repeat (80) cycle(-1);
    end

    // Asynchronous reset in the middle of a stream, then restart.
    p_ready = 70; p_redir = 5;
    repeat (10) cycle(-1);
    async_reset_pulse();
    repeat (100) cycle(-1);

`ifdef FETCH_STATS_EN
    // Run the transfer counter into saturation.
    async_reset_pulse();
    p_ready = 100; p_redir = 0;
    repeat (65560) cycle(-1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
